// File: rtl/dram_pkg.sv
// Shared constants and FSM encoding for the data-memory arbiter.
package dram_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  localparam logic [1:0] MEM_WR = 2'b10;
  localparam logic [1:0] MEM_RD = 2'b00;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_H = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker: bit 0 = core, bit 1 = host; winner 1 means host.
module rr_arb2
  import dram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio,
  output logic       winner
);

  always_comb begin
    winner = PORT_C;
    if (req == 2'b10) begin
      winner = PORT_H;
    end else if (req == 2'b11) begin
      // On a tie the host wins outright under priority, else whoever did not win last.
      winner = prio | (last == PORT_C);
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single data-memory read/write port between the core (C) and host loader (H).
module dram_arbiter
  import dram_pkg::*;
#(
  parameter bit HOST_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              c_we,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              h_req,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_we,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_h
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   mem_addr_nxt;
  logic [DATA_W-1:0]   mem_wdata_nxt;
  logic [1:0]          mem_write_nxt;
  logic                gnt_h_nxt;
  logic                last_h, last_h_nxt;
  logic                winner;

  rr_arb2 u_pick (
    .req    ({h_req, c_req}),
    .last   (last_h),
    .prio   (HOST_PRIORITY),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= MEM_RD;
      gnt_h     <= PORT_C;
      last_h    <= PORT_H;
    end else begin
      state     <= state_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_write <= mem_write_nxt;
      gnt_h     <= gnt_h_nxt;
      last_h    <= last_h_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_write_nxt = mem_write;
    gnt_h_nxt     = gnt_h;
    last_h_nxt    = last_h;

    unique case (state)
      IDLE: begin
        if (c_req || h_req) begin
          state_nxt     = ISSUE;
          gnt_h_nxt     = winner;
          last_h_nxt    = winner;
          mem_addr_nxt  = winner ? h_addr  : c_addr;
          mem_wdata_nxt = winner ? h_wdata : c_wdata;
          mem_write_nxt = (winner ? h_we : c_we) ? MEM_WR : MEM_RD;
        end
      end
      ISSUE: begin
        // Memory commits the write (or latches d_out) on the edge leaving this state.
        mem_write_nxt = MEM_RD;
        state_nxt     = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt     = IDLE;
        mem_write_nxt = MEM_RD;
      end
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    c_ack   = (state == RESP) && (gnt_h == PORT_C);
    h_ack   = (state == RESP) && (gnt_h == PORT_H);
    c_rdata = mem_rdata;
    h_rdata = mem_rdata;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter that shares the single read/write port of the data memory between the processor core (port C) and the host loader (port H). It selects one request per transaction, drives the memory address, write-data and write-control lines from registers, and returns read data and a completion pulse to the winner. The external debug read path of the data memory (extAddr/ext_d_out) bypasses this block and is not arbitrated.

## Interface
- HOST_PRIORITY, 0, 0 = round-robin between C and H; 1 = H always wins when both request
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- c_req  in  1  core request; held high with c_addr/c_wdata/c_we stable until c_ack
- c_addr  in  19  core byte address
- c_wdata  in  8  core write data
- c_we  in  1  1 = write, 0 = read
- c_ack  out  1  one-cycle completion pulse to core
- c_rdata  out  8  read data, valid only while c_ack = 1
- h_req, h_addr, h_wdata, h_we, h_ack, h_rdata  same directions, widths and meaning for host port
- mem_addr  out  19  to data memory dAddr
- mem_wdata  out  8  to data memory d_in
- mem_write  out  2  to data memory MEM_WRITE; 2'b10 = write, 2'b00 = read
- mem_rdata  in  8  from data memory d_out (registered inside memory, 1-cycle latency)
- busy  out  1  high in ISSUE and RESP
- gnt_h  out  1  owner of current/last transaction: 0 = C, 1 = H

## Operation
- FSM states IDLE, ISSUE, RESP. Reset: IDLE; mem_addr = 0, mem_wdata = 0, mem_write = 2'b00, c_ack = h_ack = 0, busy = 0, gnt_h = 0, last-grant pointer = H (so C wins first tie).
- IDLE: if no req, stay. Otherwise pick winner, register winner's addr/wdata into mem_addr/mem_wdata, mem_write = 2'b10 if we else 2'b00, gnt_h = winner, -> ISSUE.
- Winner selection: only one req -> that port. Both: HOST_PRIORITY=1 -> H; else port not granted last time. Pointer updates on every grant.
- ISSUE: memory performs write or loads d_out at end of this cycle. mem_write returns to 2'b00 on exit. -> RESP.
- RESP: assert winner's ack (Moore output); winner's rdata = mem_rdata (write ack carries don't-care data, driven as mem_rdata). Loser's ack stays 0. -> IDLE unconditionally; reqs not sampled in RESP.
- Requester must drop req or present a new transaction in the cycle after ack; loser's req stays pending and is served next.
- mem_addr/mem_wdata hold their values in IDLE (no change until next grant) so d_out stays stable.
- Req deasserted by requester before ack: protocol violation, behaviour not defined; bench must not do it.

## Timing
- Req high before edge E0 (in IDLE) -> mem_* valid after E0 -> memory acts at E1 -> ack high for the cycle between E1 and E2.
- Latency req-to-ack: 2 cycles; transaction period 3 cycles; max throughput 1 access / 3 cycles.
- Both reqs at E0: winner acked after E1, loser granted at E3 (IDLE after E2), acked after E4.
- mem_write = 2'b10 exactly one cycle (ISSUE) per write; never 2'b10 in IDLE or RESP.
- rst_n low at any time: outputs forced to reset values immediately; a write in ISSUE is aborted (mem_write = 2'b00 before the edge); no ack is issued for the aborted transaction.

## Structure
- Package dram_pkg: ADDR_W = 19, DATA_W = 8, MEM_WR = 2'b10, MEM_RD = 2'b00, FSM state encoding.
- Sub-module rr_arb2: 2-way picker, inputs req[1:0], last, prio; output winner; pure combinational, pointer kept in dram_arbiter.

## Test plan
- Reset: rst_n low -> all outputs 0, mem_write = 2'b00; release, no req -> stays IDLE, busy = 0.
- Core write then read: c_we=1, c_addr=19'h00100, c_wdata=8'hA5 -> mem_write = 2'b10 for one cycle, c_ack 2 cycles after req; then read same addr -> c_ack with c_rdata = 8'hA5.
- Simultaneous reqs, HOST_PRIORITY=0: C reads 0x00010, H reads 0x00020 -> C acked first, H acked 3 cycles later; repeat with both held -> alternates H, C, H.
- HOST_PRIORITY=1, both reqs continuously for 3 transactions each -> all H transactions complete before any C ack, then C served.
- Reset mid-write: H write 8'h3C to 0x00200, drop rst_n during ISSUE -> no h_ack, later read of 0x00200 returns old preloaded value.
- Address stability: after read ack of 0x10000 with no new req for 5 cycles -> mem_addr stays 0x10000, mem_write stays 2'b00.
